pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
Parametrised, generalised pipeline stage register that replaces the fixed-field, free-running inter-stage registers (IF/ID through MEM/WB). Carries an arbitrary DATA_W payload (data plus control sideband) with a valid/ready handshake, synchronous flush and optional 2-entry skid buffering. Also keeps a saturating back-pressure counter. One instance sits between each pair of DLX pipeline stages, so stalls and squashes become local to the stage.

Parameters:
DATA_W, 72, payload width in bits; packs data, register address and control bits (e.g. lmd + aluoutput + rd + reg/mem flags = 32+32+5+2 = 71, rounded up).
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
STALL_CNT_W, 16, width of the back-pressure cycle counter.

Ports:
clk  input  1  stage clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
flush  input  1  synchronous squash of all held entries.
in_valid  input  1  upstream stage presents a valid payload.
in_ready  output  1  stage can accept a payload this cycle.
in_data  input  DATA_W  upstream payload.
out_valid  output  1  out_data is valid.
out_ready  input  1  downstream stage accepts this cycle.
out_data  output  DATA_W  payload to downstream stage.
occupancy  output  2  number of entries held (0..2; max 1 when SKID=0).
stall_cnt  output  STALL_CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.
stall_cnt_clr  input  1  synchronous clear of stall_cnt.

Behaviour:
- Reset (reset_n=0, async, any time incl. mid-transfer): out_valid=0, out_data=0, skid entry=0, occupancy=0, stall_cnt=0. in_ready=1 (registered reset value when SKID=1). Entries held before reset are lost.
- Accept: acc = in_valid & in_ready. Emit: emt = out_valid & out_ready. Both evaluated on the same edge.
- SKID=1 states: EMPTY (occ 0), ONE (main full), TWO (main+skid full). out_data always = main register. in_ready = (state != TWO), registered, with no combinational path from out_ready.
  - EMPTY: acc -> ONE, main<=in_data.
  - ONE: acc&emt -> ONE, main<=in_data. acc&!emt -> TWO, skid<=in_data. !acc&emt -> EMPTY. Neither -> hold.
  - TWO: emt -> ONE, main<=skid. Otherwise hold. acc impossible (in_ready=0).
- SKID=0: single register. in_ready = !out_valid | out_ready (combinational). acc loads main. emt&!acc clears out_valid.
- Ordering is strict FIFO. No payload is duplicated or dropped except by flush/reset.
- Flush (highest priority after reset): next state EMPTY, out_valid=0, main and skid <= 0. A payload accepted in the flush cycle is discarded. An emit in the flush cycle is still a valid transfer to downstream. in_ready=1 from the following cycle.
- Back-pressure handling:
  - stall_cnt increments by 1 on each cycle where out_valid & !out_ready, and saturates at all-ones.
  - stall_cnt_clr has priority over increment and sets the counter to 0.
  - flush does not affect stall_cnt.
- Latency: in_data is visible on out_data one cycle after acceptance when the stage was EMPTY or emitting. Throughput is 1 payload/cycle with out_ready held high.
- Data width: payload passes bit-exact. No arithmetic is performed on the payload.

Test Plan:
1. Reset release, then in_valid=1 and out_ready=1 streaming 0x01,0x02,0x03 on consecutive cycles -> out_data 0x01,0x02,0x03 on cycles +1..+3. out_valid continuous, occupancy=1, in_ready stays 1.
2. SKID=1: out_ready=0 while 0xA and 0xB are offered -> occupancy 1 then 2, in_ready=0 the cycle after 0xB is accepted. out_ready=1 -> emits 0xA then 0xB, in_ready returns to 1.
3. Occupancy=2 with flush=1 and in_valid=1 (payload 0xC) in the same cycle -> next cycle out_valid=0, occupancy=0, out_data=0, 0xC never emitted.
4. out_valid=1, out_ready=0 held 5 cycles -> stall_cnt=5. Then stall_cnt_clr=1 -> 0. With STALL_CNT_W=3 and 10 stall cycles -> stall_cnt=7 (saturated).
5. reset_n asserted asynchronously between clock edges while occupancy=2 -> outputs reset immediately, without waiting for an edge. After release, first payload emits normally.
6. SKID=0: out_ready toggling 1,0,1 with in_valid=1 -> in_ready follows !out_valid|out_ready combinationally, no loss or duplication over 8 payloads.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register with valid/ready handshake,
// synchronous flush, optional 2-entry skid buffer and a saturating
// back-pressure cycle counter.
module pipe_stage_skid #(
    parameter int unsigned DATA_W      = 72,
    parameter int unsigned SKID        = 1,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [1:0]             occupancy,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    input  logic                   stall_cnt_clr
);

    // State value equals the number of held entries.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

    state_e                 state_q, state_d;
    logic [DATA_W-1:0]      main_q, main_d;
    logic [DATA_W-1:0]      skid_q, skid_d;
    logic                   out_valid_q, out_valid_d;
    logic                   in_ready_q, in_ready_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic                   acc_c;
    logic                   emt_c;

    // Skid mode exposes a registered ready; single-register mode lets a
    // draining downstream make room in the same cycle.
    assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid_q || out_ready);
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = 2'(state_q);
    assign stall_cnt = stall_q;

    assign acc_c = in_valid & in_ready;
    assign emt_c = out_valid_q & out_ready;

    // Next-state, payload movement and registered-output precompute.
    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;

        case (state_q)
            ST_EMPTY: begin
                if (acc_c) begin
                    state_d = ST_ONE;
                    main_d  = in_data;
                end
            end
            ST_ONE: begin
                if (acc_c && emt_c) begin
                    main_d = in_data;
                end else if (acc_c && (SKID != 0)) begin
                    skid_d  = in_data;
                    state_d = ST_TWO;
                end else if (emt_c) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (emt_c) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Squash wins over any accept; an emit this cycle still completed.
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end

        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_TWO);
    end

    // Saturating back-pressure counter; clear beats increment.
    always_comb begin
        stall_d = stall_q;
        if (stall_cnt_clr) begin
            stall_d = '0;
        end else if (out_valid_q && !out_ready && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + STALL_CNT_W'(1);
        end
    end

    // State and payload registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            stall_q     <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three instances (skid, single register,
// narrow counter) share stimulus and are checked against a bounded-FIFO
// reference model plus directed expectation tables.
module tb_pipe_stage_skid;

    localparam int unsigned DW = 72;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          stall_cnt_clr;

    logic          rdy_a, ov_a, rdy_b, ov_b, rdy_c, ov_c;
    logic [DW-1:0] od_a, od_b, od_c;
    logic [1:0]    occ_a, occ_b, occ_c;
    logic [15:0]   sc_a, sc_b;
    logic [2:0]    sc_c;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(DW), .SKID(1), .STALL_CNT_W(16)) u_a (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy_a), .in_data(in_data), .out_valid(ov_a),
        .out_ready(out_ready), .out_data(od_a), .occupancy(occ_a),
        .stall_cnt(sc_a), .stall_cnt_clr(stall_cnt_clr));

    pipe_stage_skid #(.DATA_W(DW), .SKID(0), .STALL_CNT_W(16)) u_b (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy_b), .in_data(in_data), .out_valid(ov_b),
        .out_ready(out_ready), .out_data(od_b), .occupancy(occ_b),
        .stall_cnt(sc_b), .stall_cnt_clr(stall_cnt_clr));

    pipe_stage_skid #(.DATA_W(DW), .SKID(1), .STALL_CNT_W(3)) u_c (
        .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid),
        .in_ready(rdy_c), .in_data(in_data), .out_valid(ov_c),
        .out_ready(out_ready), .out_data(od_c), .occupancy(occ_c),
        .stall_cnt(sc_c), .stall_cnt_clr(stall_cnt_clr));

    logic          d_rdy [3];
    logic          d_ov  [3];
    logic [DW-1:0] d_od  [3];
    logic [1:0]    d_occ [3];
    logic [15:0]   d_sc  [3];

    always_comb begin
        d_rdy[0] = rdy_a; d_ov[0] = ov_a; d_od[0] = od_a; d_occ[0] = occ_a; d_sc[0] = sc_a;
        d_rdy[1] = rdy_b; d_ov[1] = ov_b; d_od[1] = od_b; d_occ[1] = occ_b; d_sc[1] = sc_b;
        d_rdy[2] = rdy_c; d_ov[2] = ov_c; d_od[2] = od_c; d_occ[2] = occ_c; d_sc[2] = 16'(sc_c);
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a bounded FIFO per instance plus a stall tally.
    logic [DW-1:0] m_e  [3][2];
    int            m_n  [3];
    logic [15:0]   m_sc [3];

    function automatic int cap(input int i);
        return (i == 1) ? 1 : 2;
    endfunction

    function automatic logic [15:0] sc_max(input int i);
        return (i == 2) ? 16'd7 : 16'hFFFF;
    endfunction

    function automatic logic m_rdy(input int i);
        if (cap(i) == 2) return (m_n[i] < 2);
        return (m_n[i] == 0) || out_ready;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] @%0t got %h expected %h", nm, idx, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_n[i]  = 0;
            m_sc[i] = '0;
            m_e[i][0] = '0;
            m_e[i][1] = '0;
        end
    endtask

    task automatic compare_model();
        for (int i = 0; i < 3; i++) begin
            chk("in_ready",  i, DW'(d_rdy[i]), DW'(m_rdy(i)));
            chk("out_valid", i, DW'(d_ov[i]),  DW'(m_n[i] > 0));
            chk("occupancy", i, DW'(d_occ[i]), DW'(m_n[i]));
            chk("stall_cnt", i, DW'(d_sc[i]),  DW'(m_sc[i]));
            if (m_n[i] > 0) chk("out_data", i, d_od[i], m_e[i][0]);
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            logic acc, emt;
            acc = in_valid && m_rdy(i);
            emt = (m_n[i] > 0) && out_ready;
            if (stall_cnt_clr) m_sc[i] = '0;
            else if ((m_n[i] > 0) && !out_ready && (m_sc[i] != sc_max(i))) m_sc[i] = m_sc[i] + 16'd1;
            if (flush) begin
                m_n[i] = 0;
            end else begin
                if (emt) begin
                    m_e[i][0] = m_e[i][1];
                    m_n[i]    = m_n[i] - 1;
                end
                if (acc) begin
                    m_e[i][m_n[i]] = in_data;
                    m_n[i]         = m_n[i] + 1;
                end
            end
        end
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic orr,
                         input logic fl, input logic clr);
        in_valid      = iv;
        in_data       = d;
        out_ready     = orr;
        flush         = fl;
        stall_cnt_clr = clr;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance();
        compare_model();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          orr;
        logic          fl;
        logic          e_ov;
        logic          chk_od;
        logic [DW-1:0] e_od;
        logic [1:0]    e_occ;
        logic          e_rdy;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic orr,
                                input logic fl, input logic e_ov, input logic chk_od,
                                input logic [7:0] e_od, input logic [1:0] e_occ,
                                input logic e_rdy);
        vec_t v;
        v.iv = iv; v.d = DW'(d); v.orr = orr; v.fl = fl; v.e_ov = e_ov;
        v.chk_od = chk_od; v.e_od = DW'(e_od); v.e_occ = e_occ; v.e_rdy = e_rdy;
        return v;
    endfunction

    vec_t          tbl [18];
    logic [DW-1:0] log_b [16];
    int            n_log;
    int            k;

    initial begin
        // Expected behaviour of the skid instance, observed before each edge.
        //            iv  d     or fl  ov cod od    occ rdy
        tbl[0]  = mk(1, 8'h01, 1, 0,  0, 1, 8'h00, 0, 1);
        tbl[1]  = mk(1, 8'h02, 1, 0,  1, 1, 8'h01, 1, 1);
        tbl[2]  = mk(1, 8'h03, 1, 0,  1, 1, 8'h02, 1, 1);
        tbl[3]  = mk(0, 8'h00, 1, 0,  1, 1, 8'h03, 1, 1);
        tbl[4]  = mk(0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1);
        tbl[5]  = mk(1, 8'h0A, 0, 0,  0, 0, 8'h00, 0, 1);
        tbl[6]  = mk(1, 8'h0B, 0, 0,  1, 1, 8'h0A, 1, 1);
        tbl[7]  = mk(1, 8'h0D, 0, 0,  1, 1, 8'h0A, 2, 0);
        tbl[8]  = mk(0, 8'h00, 1, 0,  1, 1, 8'h0A, 2, 0);
        tbl[9]  = mk(0, 8'h00, 1, 0,  1, 1, 8'h0B, 1, 1);
        tbl[10] = mk(0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1);
        tbl[11] = mk(1, 8'h11, 0, 0,  0, 0, 8'h00, 0, 1);
        tbl[12] = mk(1, 8'h12, 0, 0,  1, 1, 8'h11, 1, 1);
        tbl[13] = mk(1, 8'h0C, 0, 1,  1, 1, 8'h11, 2, 0);
        tbl[14] = mk(0, 8'h00, 1, 0,  0, 1, 8'h00, 0, 1);
        tbl[15] = mk(1, 8'h21, 0, 0,  0, 0, 8'h00, 0, 1);
        tbl[16] = mk(1, 8'h22, 0, 1,  1, 1, 8'h21, 1, 1);
        tbl[17] = mk(0, 8'h00, 1, 0,  0, 1, 8'h00, 0, 1);

        reset_n = 1'b0;
        drive(0, '0, 0, 0, 0);
        model_reset();
        #12;
        for (int i = 0; i < 3; i++) begin
            chk("rst_out_valid", i, DW'(d_ov[i]),  '0);
            chk("rst_out_data",  i, d_od[i],       '0);
            chk("rst_occupancy", i, DW'(d_occ[i]), '0);
            chk("rst_stall_cnt", i, DW'(d_sc[i]),  '0);
            chk("rst_in_ready",  i, DW'(d_rdy[i]), DW'(1));
        end
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Streaming, skid fill/drain and flush sequences.
        for (int r = 0; r < 18; r++) begin
            drive(tbl[r].iv, tbl[r].d, tbl[r].orr, tbl[r].fl, 0);
            settle();
            chk("tbl_out_valid", r, DW'(ov_a),  DW'(tbl[r].e_ov));
            chk("tbl_occupancy", r, DW'(occ_a), DW'(tbl[r].e_occ));
            chk("tbl_in_ready",  r, DW'(rdy_a), DW'(tbl[r].e_rdy));
            if (tbl[r].chk_od) chk("tbl_out_data", r, od_a, tbl[r].e_od);
            advance();
        end

        // Asynchronous reset between edges while two entries are held.
        drive(1, DW'(8'h51), 0, 0, 0); settle(); advance();
        drive(1, DW'(8'h52), 0, 0, 0); settle(); advance();
        drive(0, '0, 0, 0, 0);
        settle();
        chk("pre_rst_occ", 0, DW'(occ_a), DW'(2));
        #2;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("arst_out_valid", i, DW'(d_ov[i]),  '0);
            chk("arst_out_data",  i, d_od[i],       '0);
            chk("arst_occupancy", i, DW'(d_occ[i]), '0);
            chk("arst_stall_cnt", i, DW'(d_sc[i]),  '0);
            chk("arst_in_ready",  i, DW'(d_rdy[i]), DW'(1));
        end
        model_reset();
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1, DW'(8'h60), 1, 0, 0); settle(); advance();
        drive(0, '0, 1, 0, 0); settle();
        chk("post_rst_valid", 0, DW'(ov_a), DW'(1));
        chk("post_rst_data",  0, od_a, DW'(8'h60));
        advance();
        drive(0, '0, 1, 0, 0); settle(); advance();

        // Back-pressure counting, saturation of the narrow counter, clear.
        drive(1, DW'(8'h33), 0, 0, 1); settle(); advance();
        for (int c = 0; c < 5; c++) begin
            drive(0, '0, 0, 0, 0); settle(); advance();
        end
        settle();
        chk("stall5_a", 0, DW'(sc_a), DW'(5));
        chk("stall5_c", 2, DW'(sc_c), DW'(5));
        advance();
        for (int c = 0; c < 4; c++) begin
            settle(); advance();
        end
        settle();
        chk("stall10_a", 0, DW'(sc_a), DW'(10));
        chk("stall_sat_c", 2, DW'(sc_c), DW'(7));
        drive(0, '0, 0, 0, 1); advance();
        drive(0, '0, 1, 0, 0); settle();
        chk("stall_clr_a", 0, DW'(sc_a), '0);
        chk("stall_clr_c", 2, DW'(sc_c), '0);
        advance();
        for (int c = 0; c < 3; c++) begin
            settle(); advance();
        end

        // Single-register instance with toggling out_ready: 8 payloads in order.
        k     = 0;
        n_log = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            logic acc_b;
            drive((k < 8), DW'(8'h40 + k[7:0]), (cyc % 2 == 0), 0, 0);
            settle();
            if (ov_b && out_ready && n_log < 16) begin
                log_b[n_log] = od_b;
                n_log++;
            end
            acc_b = in_valid && m_rdy(1);
            advance();
            if (acc_b) k++;
        end
        chk("b_emit_count", 1, DW'(n_log), DW'(8));
        for (int j = 0; j < 8; j++) chk("b_emit_order", j, log_b[j], DW'(8'h40 + j));

        // Randomised traffic against the model.
        for (int c = 0; c < 600; c++) begin
            drive(($urandom % 4) != 0, DW'({$urandom, $urandom, $urandom}),
                  ($urandom % 3) != 0, ($urandom % 32) == 0, ($urandom % 64) == 0);
            settle();
            advance();
        end
        drive(0, '0, 1, 0, 0);
        settle();
        advance();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
